jk_bank_sched: RTL and testbench
================================

Name: jk_bank_sched

Overview:
Shared-access scheduler for a bank of WIDTH JK flip-flop cells. Two requesters submit masked JK commands (hold, clear, set, toggle), each with a repeat count. A round-robin arbiter picks one command at a time, and the sequencer drives the bank's J/K vectors for count+1 consecutive cycles. The block is the single owner of the flag/status register bank; requesters see only the Q vector and a done pulse.

Parameters:
WIDTH, 8, number of JK cells in the bank
CNT_W, 4, width of the repeat-count field (max count+1 = 2^CNT_W applications)

Ports:
CLK  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 command valid; held until gnt0
op0  in  2  requester 0 op: 00 hold, 01 clear, 10 set, 11 toggle (= {J,K})
mask0  in  WIDTH  requester 0 bit select
cnt0  in  CNT_W  requester 0 repeat count (applications = cnt0+1)
gnt0  out  1  requester 0 command accepted this cycle
req1/op1/mask1/cnt1/gnt1  same as above, requester 1
busy  out  1  command in progress (state RUN)
done  out  1  one-cycle pulse after the last application
owner  out  1  index of the requester whose command is latched/last ran
Q  out  WIDTH  bank state

Behaviour:
- Reset (Reset_n low, async): Q=0, state IDLE, rr pointer=0 (req0 preferred), owner=0, busy=0, done=0, rem=0. gnt0/gnt1 are forced 0 while Reset_n is low.
- States: IDLE and RUN only.
- IDLE: gnt is combinational from req and the rr pointer. If only one req is high, grant it. If both are high, grant the pointer's side. Only one gnt may be high in any cycle.
- Acceptance = req & gnt at a rising edge. At that edge:
  - latch op, mask and cnt into cmd registers and rem=cnt;
  - owner = granted index; pointer = other index;
  - state -> RUN.
- RUN: busy=1, gnt0=gnt1=0. Bank inputs are J = op[1] & mask and K = op[0] & mask; unmasked bits see J=K=0.
- Each RUN edge, the bank applies the JK rule per bit:
  - 00 hold; 01 Q<=0; 10 Q<=1; 11 Q<=~Q.
  - If rem==0: state -> IDLE and done<=1 for one cycle.
  - Otherwise rem<=rem-1.
- Latency: an accept at edge E0 causes Q updates at E1..E1+cnt. done is high in the cycle following edge E1+cnt.
- Back-to-back: the done cycle is IDLE, so a new grant may occur in that same cycle. Maximum throughput is one command per cnt+2 cycles.
- Outside RUN, J=K=0 and Q holds.
- Boundary cases:
  - mask=0 or op=00: still occupies cnt+1 RUN cycles; Q unchanged; done pulses.
  - cnt=0: single application.
  - cnt=all-ones: 2^CNT_W applications; rem must not wrap.
  - Toggle with even application count leaves Q unchanged; odd count inverts the masked bits.
  - A req deasserted before gnt: no command, no error.
  - op/mask/cnt changes during RUN have no effect, since they are latched.
  - Reset mid-RUN: immediate abort; Q=0, IDLE, no done pulse.
  - Both reqs high continuously: grants strictly alternate.

Decomposition:
- Package jk_sched_pkg holds:
  - op encoding constants OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TGL=2'b11;
  - state encoding ST_IDLE/ST_RUN.
- One sub-module, jk_bank: WIDTH JK cells with shared CLK/Reset_n, vector J/K in, Q out, same per-bit JK rule, async active-low clear.
- The arbiter and sequencer stay in jk_bank_sched.

Test Plan:
- Reset then idle: Reset_n low mid-cycle -> Q=8'h00, busy=0, gnt0=gnt1=0 immediately; no reqs for 5 cycles -> Q stays 8'h00, done never pulses.
- Single set: req0, op0=10, mask0=8'hA5, cnt0=0 -> gnt0 for 1 cycle; Q=8'hA5 one edge later; done pulses next cycle; busy high exactly 1 cycle.
- Repeated toggle:
  - from Q=8'hA5, req1, op1=11, mask1=8'h0F, cnt1=2 -> Q=8'hAA, 8'hA5, 8'hAA on successive edges;
  - busy high 3 cycles; one done; owner=1.
- Arbitration: req0 and req1 both held high with cnt=0 after reset -> grant order 0,1,0,1. Each grant follows the preceding done cycle (gnt coincident with done), and gnt0 and gnt1 are never both high.
- Max count: op=01, mask=8'hFF, cnt=4'hF from Q=8'hFF -> Q=8'h00 after the first edge; busy high 16 cycles; exactly one done.
- Reset mid-RUN: toggle with cnt=7 in progress, Reset_n pulsed low at the 3rd RUN cycle -> Q=8'h00, busy=0 asynchronously, no done. After release, a pending req0 is granted first.

Source files
------------

// File: rtl/jk_sched_pkg.sv
// Shared encodings for the JK bank scheduler: op codes ({J,K}) and sequencer states.
package jk_sched_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH independent JK flip-flops sharing one clock and an async active-low clear.
module jk_bank
    import jk_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic q_d;
            logic q_q;

            always_comb begin
                q_d = q_q;
                case ({J[gi], K[gi]})
                    OP_CLR:  q_d = 1'b0;
                    OP_SET:  q_d = 1'b1;
                    OP_TGL:  q_d = ~q_q;
                    default: q_d = q_q;
                endcase
            end

            always_ff @(posedge CLK or negedge Reset_n) begin
                if (!Reset_n) begin
                    q_q <= 1'b0;
                end else begin
                    q_q <= q_d;
                end
            end

            assign Q[gi] = q_q;
        end
    endgenerate

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler for two requesters issuing masked, repeated JK commands to one bank.
module jk_bank_sched
    import jk_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] mask0,
    input  logic [CNT_W-1:0] cnt0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] mask1,
    input  logic [CNT_W-1:0] cnt1,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] Q
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic             done_q, done_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] bank_j, bank_k;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        done_d  = 1'b0;
        op_d    = op_q;
        mask_d  = mask_q;
        rem_d   = rem_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        if (state_q == ST_IDLE) begin
            // Grants are gated by reset so nothing is offered while the bank is held clear.
            gnt0 = Reset_n & req0 & (~req1 | ~ptr_q);
            gnt1 = Reset_n & req1 & (~req0 |  ptr_q);
            if (gnt0 || gnt1) begin
                op_d    = gnt1 ? op1   : op0;
                mask_d  = gnt1 ? mask1 : mask0;
                rem_d   = gnt1 ? cnt1  : cnt0;
                owner_d = gnt1;
                ptr_d   = gnt0;
                state_d = ST_RUN;
            end
        end else begin
            if (rem_q == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                rem_d = rem_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= OP_HOLD;
            mask_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            done_q  <= done_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            rem_q   <= rem_d;
        end
    end

    assign bank_j = (state_q == ST_RUN) ? ({WIDTH{op_q[1]}} & mask_q) : '0;
    assign bank_k = (state_q == ST_RUN) ? ({WIDTH{op_q[0]}} & mask_q) : '0;

    jk_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .J      (bank_j),
        .K      (bank_k),
        .Q      (Q)
    );

    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed bench for jk_bank_sched: reset, set, toggle, arbitration, max count, reset mid-run.
module tb_jk_bank_sched;

    logic       CLK;
    logic       Reset_n;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] mask0, mask1;
    logic [3:0] cnt0, cnt1;
    logic       gnt0, gnt1, busy, done, owner;
    logic [7:0] Q;

    int total = 0;
    int bad   = 0;

    int         nbusy, ndone;
    logic [7:0] q1;

    jk_bank_sched #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .req0   (req0),
        .op0    (op0),
        .mask0  (mask0),
        .cnt0   (cnt0),
        .gnt0   (gnt0),
        .req1   (req1),
        .op1    (op1),
        .mask1  (mask1),
        .cnt1   (cnt1),
        .gnt1   (gnt1),
        .busy   (busy),
        .done   (done),
        .owner  (owner),
        .Q      (Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue one command from a negedge, then count busy cycles and done pulses until completion.
    task automatic run_cmd(input bit who, input logic [1:0] op, input logic [7:0] mask,
                           input logic [3:0] cnt, output int nb, output int nd,
                           output logic [7:0] qf);
        nb = 0;
        nd = 0;
        qf = 'x;
        if (!who) begin
            req0 = 1'b1; op0 = op; mask0 = mask; cnt0 = cnt;
        end else begin
            req1 = 1'b1; op1 = op; mask1 = mask; cnt1 = cnt;
        end
        #1;
        chk("gnt_sel", {30'd0, gnt1, gnt0}, who ? 32'h2 : 32'h1);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                req0 = 1'b0; req1 = 1'b0;
                op0 = ~op; op1 = ~op; mask0 = ~mask; mask1 = ~mask; cnt0 = '0; cnt1 = '0;
            end
            if (busy) nb++;
            if (done) nd++;
            if (i == 1) qf = Q;
            if (done) break;
        end
        @(negedge CLK);
        if (done) nd++;
    endtask

    initial begin
        Reset_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        mask0 = '0; mask1 = '0;
        cnt0 = '0; cnt1 = '0;

        // Reset asserted mid-cycle with a request pending
        #3;
        Reset_n = 1'b0;
        req0 = 1'b1;
        #1;
        chk("rst_q", Q, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        @(negedge CLK);
        req0 = 1'b0;
        @(negedge CLK);
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("idle_q", Q, 8'h00);
            chk("idle_done", done, 1'b0);
        end

        // Single set, cnt=0
        run_cmd(1'b0, 2'b10, 8'hA5, 4'h0, nbusy, ndone, q1);
        chk("set_q", Q, 8'hA5);
        chk("set_busy", nbusy, 1);
        chk("set_done", ndone, 1);
        chk("set_owner", owner, 1'b0);

        // Toggle low nibble three times from requester 1
        run_cmd(1'b1, 2'b11, 8'h0F, 4'h2, nbusy, ndone, q1);
        chk("tgl_q1", q1, 8'hAA);
        chk("tgl_q", Q, 8'hAA);
        chk("tgl_busy", nbusy, 3);
        chk("tgl_done", ndone, 1);
        chk("tgl_owner", owner, 1'b1);

        // Arbitration after reset: both requesters held high
        Reset_n = 1'b0;
        #1;
        chk("rst2_q", Q, 8'h00);
        @(negedge CLK);
        Reset_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        op0 = 2'b00; op1 = 2'b00; mask0 = 8'h00; mask1 = 8'h00; cnt0 = '0; cnt1 = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("arb_gnt", {gnt1, gnt0}, ((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
                if (k > 0) chk("arb_done", done, 1'b1);
            end else begin
                chk("arb_run", {gnt1, gnt0}, 2'b00);
            end
            chk("arb_excl", gnt0 & gnt1, 1'b0);
            @(negedge CLK);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge CLK);

        // Max count clear from all-ones
        run_cmd(1'b0, 2'b10, 8'hFF, 4'h0, nbusy, ndone, q1);
        chk("pre_max_q", Q, 8'hFF);
        run_cmd(1'b0, 2'b01, 8'hFF, 4'hF, nbusy, ndone, q1);
        chk("max_q1", q1, 8'h00);
        chk("max_busy", nbusy, 16);
        chk("max_done", ndone, 1);

        // Reset mid-run: toggle all bits with cnt=7, abort in the third RUN cycle
        run_cmd(1'b1, 2'b10, 8'h3C, 4'h0, nbusy, ndone, q1);
        chk("pre_rr_q", Q, 8'h3C);
        req0 = 1'b1; op0 = 2'b11; mask0 = 8'hFF; cnt0 = 4'h7;
        #1;
        chk("rr_gnt", {gnt1, gnt0}, 2'b01);
        @(negedge CLK);
        req0 = 1'b0;
        @(negedge CLK);
        chk("rr_q2", Q, 8'hC3);
        @(negedge CLK);
        chk("rr_q3", Q, 8'h3C);
        chk("rr_busy3", busy, 1'b1);
        #2;
        Reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        op0 = 2'b00; op1 = 2'b00; cnt0 = '0; cnt1 = '0;
        #1;
        chk("rr_q", Q, 8'h00);
        chk("rr_busy", busy, 1'b0);
        chk("rr_done", done, 1'b0);
        chk("rr_gnt_rst", {gnt1, gnt0}, 2'b00);
        @(negedge CLK);
        chk("rr_done2", done, 1'b0);
        Reset_n = 1'b1;
        #1;
        chk("rr_first", {gnt1, gnt0}, 2'b01);
        @(negedge CLK);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
